disparity_out_scheduler: RTL
============================

Name: disparity_out_scheduler

Overview:
- Sequences the 6-bit disparity stream from the matching pipeline into the disparity-to-grey output decoder.
- Frames the stream against a frame_start strobe and generates raster coordinates for the display/frame-buffer writer.
- Absorbs sink back-pressure in a small FIFO and flags overflow when the sink stalls too long.
- Sits between the disparity search core and the output decoder; decoder valid/data inputs are driven only by this block.

Parameters:
- H_ACTIVE, 320, pixels per line
- V_ACTIVE, 240, lines per frame
- FIFO_DEPTH, 8, FIFO entries; power of 2, minimum 2
- X_W, 9, width of pix_x; must satisfy 2^X_W >= H_ACTIVE
- Y_W, 8, width of pix_y; must satisfy 2^Y_W >= V_ACTIVE

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- frame_start  input  1  one-cycle strobe that begins a frame
- in_valid  input  1  disparity sample valid
- in_data  input  6  disparity sample
- out_ready  input  1  sink can accept one pixel this cycle
- dec_valid  output  1  valid to the output decoder; one-cycle pulse per pixel
- dec_data  output  6  disparity to the output decoder
- pix_x  output  X_W  column of the current dec_valid pixel
- pix_y  output  Y_W  line of the current dec_valid pixel
- frame_done  output  1  one-cycle pulse after the last pixel is issued
- frame_abort  output  1  one-cycle pulse when frame_start restarts an unfinished frame
- overflow  output  1  sticky FIFO-overflow / excess-input flag
- busy  output  1  high in ACTIVE and DONE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; FIFO empty; all counters 0.
- Reset values: dec_valid=0, dec_data=0, pix_x=0, pix_y=0, frame_done=0, frame_abort=0, overflow=0, busy=0.
- Reset asserted mid-frame discards all buffered data immediately.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - in_valid is ignored; no push and no overflow.
  - frame_start -> ACTIVE; clears FIFO, push counter, pix counters and overflow.
- ACTIVE, push:
  - in_valid with push count < H_ACTIVE*V_ACTIVE writes in_data to the FIFO.
  - Push while full is permitted only if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set.
  - in_valid after H_ACTIVE*V_ACTIVE samples have been pushed: dropped, overflow set.
- ACTIVE, pop:
  - Pop when FIFO not empty and out_ready=1 (out_ready sampled in the same cycle).
  - Next cycle: dec_valid=1, dec_data=popped value, pix_x/pix_y = coordinates of that pixel.
  - dec_valid is 0 in every cycle without a pop; dec_data, pix_x and pix_y hold their last values.
- Coordinate counters:
  - pix_x increments per pop and wraps from H_ACTIVE-1 to 0.
  - pix_y increments on that wrap.
  - The first pixel of a frame is (0,0).
- ACTIVE -> DONE: in the cycle the pixel at (H_ACTIVE-1, V_ACTIVE-1) is issued on dec_valid.
- DONE (one cycle): frame_done=1, then -> IDLE.
- frame_start during ACTIVE or DONE:
  - Restart: FIFO flushed, counters cleared, overflow cleared, state=ACTIVE.
  - frame_abort=1 for one cycle; frame_done suppressed.
  - A same-cycle in_valid belongs to the new frame and is pushed.
- Latency: with FIFO empty and out_ready=1, in_valid at cycle N gives dec_valid at N+2.
- Throughput: sustained one pixel per clock.
- overflow stays high until the next frame_start or reset.
- Decoder contract: the decoder adds one more cycle of latency; this block never needs to stall it.

Test Plan:
- Streaming: reset; frame_start; H_ACTIVE*V_ACTIVE in_valid back-to-back with out_ready=1 and data=count mod 64.
  - Expect dec_valid 2 cycles after each input.
  - Expect pix_x/pix_y to walk raster order: (319,0)->(0,1), last pixel (319,239).
  - Expect frame_done one cycle after the last pixel; overflow=0.
- Back-pressure fill: out_ready=0 for 8 pushes (FIFO full), then push and pop in the same cycle.
  - Expect the push accepted, overflow=0, data order preserved.
- Overflow: out_ready=0, 9 consecutive pushes.
  - Expect 9th sample dropped, overflow=1.
  - After out_ready=1, expect exactly 8 pixels out, matching the first 8 values.
- Idle and excess inputs: in_valid while IDLE gives no dec_valid and overflow=0.
  - In ACTIVE, sample H_ACTIVE*V_ACTIVE+1 is dropped and sets overflow.
- Restart: frame_start after 100 pixels.
  - Expect frame_abort pulse, no frame_done, next dec_valid at (0,0) carrying the first sample of the new frame.
- Reset: assert reset mid-frame with FIFO half full.
  - Expect all outputs 0 immediately (asynchronous).
  - Expect no dec_valid until after a new frame_start.

Source files
------------

// File: rtl/disparity_out_scheduler.sv
// disparity_out_scheduler
// Frames the 6-bit disparity stream against frame_start, buffers it in a
// small FIFO to absorb sink back-pressure, and issues one pixel per pop to
// the disparity-to-grey decoder together with its raster coordinates.
module disparity_out_scheduler #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int DATA_W     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_data,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              overflow,
  output logic              busy
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FILL_W    = $clog2(FIFO_DEPTH + 1);
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int PUSH_W    = $clog2(FRAME_PIX + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);
  localparam logic [PUSH_W-1:0] PUSH_MAX  = PUSH_W'(FRAME_PIX);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_addr;
  logic [FILL_W-1:0] fill;
  logic [PUSH_W-1:0] push_cnt;
  logic [X_W-1:0]    next_x;
  logic [Y_W-1:0]    next_y;

  logic              streaming;
  logic              fifo_empty, fifo_full;
  logic              quota_ok, room_ok;
  logic              pop_p0, push_p0, drop_p0;
  logic              last_issued;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [X_W-1:0]    x_p1;
  logic [Y_W-1:0]    y_p1;
  logic              ovf_q;

  // ---- stage p0: push/pop decisions against the FIFO ----
  // A frame_start always wins: the old frame is flushed and any same-cycle
  // sample becomes the first entry of the new frame.
  assign streaming  = (state_q == ST_ACTIVE) && !frame_start;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == FILL_FULL);
  assign pop_p0     = streaming && !fifo_empty && out_ready;
  assign quota_ok   = (push_cnt < PUSH_MAX);
  assign room_ok    = !fifo_full || pop_p0;
  assign push_p0    = in_valid && (frame_start || (streaming && quota_ok && room_ok));
  assign drop_p0    = in_valid && streaming && !(quota_ok && room_ok);
  assign wr_addr    = frame_start ? '0 : wr_ptr;

  // FIFO pointers, fill level and per-frame push count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      push_cnt <= '0;
    end else if (frame_start) begin
      rd_ptr   <= '0;
      wr_ptr   <= PTR_W'(in_valid);
      fill     <= FILL_W'(in_valid);
      push_cnt <= PUSH_W'(in_valid);
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_p0)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_p0 && !pop_p0)      fill <= fill + FILL_W'(1);
      else if (!push_p0 && pop_p0) fill <= fill - FILL_W'(1);
      if (push_p0) push_cnt <= push_cnt + PUSH_W'(1);
    end
  end

  // FIFO storage; contents are meaningless once the pointers are cleared
  always_ff @(posedge clock) begin
    if (push_p0) fifo_mem[wr_addr] <= in_data;
  end

  // Raster position of the next pixel to be popped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      next_x <= '0;
      next_y <= '0;
    end else if (frame_start) begin
      next_x <= '0;
      next_y <= '0;
    end else if (pop_p0) begin
      if (next_x == X_LAST) begin
        next_x <= '0;
        next_y <= next_y + Y_W'(1);
      end else begin
        next_x <= next_x + X_W'(1);
      end
    end
  end

  // ---- stage p1: registered decoder interface ----
  // Pulse valid for each pop; data and coordinates hold between pops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      x_p1    <= '0;
      y_p1    <= '0;
    end else begin
      vld_p1 <= pop_p0;
      if (pop_p0) begin
        data_p1 <= fifo_mem[rd_ptr];
        x_p1    <= next_x;
        y_p1    <= next_y;
      end
    end
  end

  // Sticky overflow, cleared only by a new frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            ovf_q <= 1'b0;
    else if (frame_start) ovf_q <= 1'b0;
    else if (drop_p0)     ovf_q <= 1'b1;
  end

  assign dec_valid   = vld_p1;
  assign dec_data    = data_p1;
  assign pix_x       = x_p1;
  assign pix_y       = y_p1;
  assign overflow    = ovf_q;
  assign last_issued = vld_p1 && (x_p1 == X_LAST) && (y_p1 == Y_LAST);

  // Frame state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: frame_start restarts from any state; the frame ends once
  // its last pixel has been presented to the decoder
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (frame_start) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (frame_start)      state_d = ST_ACTIVE;
        else if (last_issued) state_d = ST_DONE;
      end
      ST_DONE:   state_d = frame_start ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Status outputs; a restart suppresses frame_done and reports an abort
  always_comb begin
    busy        = (state_q != ST_IDLE);
    frame_done  = (state_q == ST_DONE) && !frame_start;
    frame_abort = frame_start && (state_q != ST_IDLE);
  end

endmodule
